// File: rtl/bus_sram_responder.sv
// bus_sram_responder: word-addressed on-chip SRAM target for the shared processor bus.
// Optional build macro BUS_SRAM_RESP_WAIT_EN injects a busy cycle every WAIT_PERIOD burst beats.
module bus_sram_responder #(
   parameter logic [31:0] BASE_ADDR   = 32'h5000_0000,
   parameter int          ADDR_W      = 10,
   parameter int          WAIT_PERIOD = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        beginTransactionIn,
   input  logic [31:0] addressDataIn,
   input  logic [3:0]  byteEnablesIn,
   input  logic [7:0]  burstSizeIn,
   input  logic        readNotWriteIn,
   input  logic        dataValidIn,
   input  logic        endTransactionIn,
   output logic [31:0] addressDataOut,
   output logic        dataValidOut,
   output logic        endTransactionOut,
   output logic        busErrorOut,
   output logic        busyOut
);

`ifdef BUS_SRAM_RESP_WAIT_EN
   localparam bit WAIT_EN = 1'b1;
`else
   localparam bit WAIT_EN = 1'b0;
`endif
   localparam logic [15:0] WAIT_LAST = 16'(WAIT_PERIOD - 1);

   typedef enum logic [2:0] {
      IDLE,
      RD_LAT,
      RD_BURST,
      RD_END,
      WRITE,
      ERR
   } state_e;

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   idx_q, idx_d;
   logic [7:0]          cnt_q, cnt_d;
   logic                done_q, done_d;
   logic                hold_q, hold_d;
   logic [15:0]         wcnt_q, wcnt_d;

   logic                mem_we;
   logic                mem_re;
   logic [31:0]         mem_rdata;
   logic [31:0]         mem [0:2**ADDR_W-1];

   logic                hit;
   logic                unused_addr_lsbs;

   assign hit              = addressDataIn[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2];
   assign unused_addr_lsbs = ^addressDataIn[1:0];

   // NOTE: every signal gets its default before the case, so no path leaves one
   // unassigned and no latch is inferred.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      done_d  = done_q;
      hold_d  = 1'b0;
      wcnt_d  = wcnt_q;
      mem_we  = 1'b0;
      mem_re  = 1'b0;

      case (state_q)
         IDLE: begin
            done_d = 1'b0;
            wcnt_d = '0;
            if (beginTransactionIn) begin
               if (hit) begin
                  idx_d   = addressDataIn[ADDR_W+1:2];
                  cnt_d   = burstSizeIn;
                  state_d = readNotWriteIn ? RD_LAT : WRITE;
               end else begin
                  state_d = ERR;
               end
            end
         end

         RD_LAT: begin
            mem_re  = 1'b1;
            idx_d   = idx_q + 1'b1;
            state_d = RD_BURST;
         end

         RD_BURST: begin
            // A busy cycle delivers nothing; the prefetched word waits in mem_rdata.
            if (!hold_q) begin
               if (cnt_q == 8'd0) begin
                  state_d = RD_END;
               end else begin
                  cnt_d  = cnt_q - 8'd1;
                  mem_re = 1'b1;
                  idx_d  = idx_q + 1'b1;
                  if (WAIT_EN) begin
                     if (wcnt_q == WAIT_LAST) begin
                        wcnt_d = '0;
                        hold_d = 1'b1;
                     end else begin
                        wcnt_d = wcnt_q + 16'd1;
                     end
                  end
               end
            end
         end

         RD_END: state_d = IDLE;

         WRITE: begin
            // During a busy cycle the initiator holds its beat, end included.
            if (!hold_q) begin
               if (dataValidIn && !done_q) begin
                  mem_we = 1'b1;
                  idx_d  = idx_q + 1'b1;
                  if (cnt_q == 8'd0) begin
                     done_d = 1'b1;
                  end else begin
                     cnt_d = cnt_q - 8'd1;
                     if (WAIT_EN) begin
                        if (wcnt_q == WAIT_LAST) begin
                           wcnt_d = '0;
                           hold_d = 1'b1;
                        end else begin
                           wcnt_d = wcnt_q + 16'd1;
                        end
                     end
                  end
               end
               if (endTransactionIn) begin
                  hold_d  = 1'b0;
                  state_d = IDLE;
               end
            end
         end

         ERR: state_d = IDLE;

         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         idx_q   <= '0;
         cnt_q   <= '0;
         done_q  <= 1'b0;
         hold_q  <= 1'b0;
         wcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
         hold_q  <= hold_d;
         wcnt_q  <= wcnt_d;
      end
   end

   // NOTE: the array and its read register have no reset; SRAM contents are
   // undefined after reset, and a reset would prevent RAM inference.
   always_ff @(posedge clock) begin
      if (mem_we) begin
         for (int b = 0; b < 4; b++) begin
            if (byteEnablesIn[b]) mem[idx_q][8*b +: 8] <= addressDataIn[8*b +: 8];
         end
      end
      if (mem_re) mem_rdata <= mem[idx_q];
   end

   // Outputs decode from reset flops only, so they are zero when not driving.
   assign dataValidOut      = (state_q == RD_BURST) && !hold_q;
   assign addressDataOut    = dataValidOut ? mem_rdata : '0;
   assign endTransactionOut = state_q == RD_END;
   assign busErrorOut       = state_q == ERR;
   assign busyOut           = hold_q;

endmodule
